arb_result_dispatch: RTL and testbench

//  Read side of the arbiter -> FIFO path. Pops tagged entries from the shared

---
 rtl/arb_result_dispatch.sv | 181 ++++++++++++++++++
 tb/tb_arb_result_dispatch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/arb_result_dispatch.sv
// arb_result_dispatch
// Read side of the arbiter -> FIFO path. Pops one tagged entry at a time,
// routes it to master 0 or 1 by its source bit, counts delivered beats per
// source to flag frame completion, and counts entries discarded as mode 00.
module arb_result_dispatch #(
  parameter int DW          = 32,
  parameter int FRAME_BEATS = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [DW+10:0]   fifo_rd_data,
  output logic             mstr0_valid,
  input  logic             mstr0_ready,
  output logic [1:0]       mstr0_mode,
  output logic [7:0]       mstr0_proc_val,
  output logic [DW-1:0]    mstr0_data,
  output logic             mstr0_cmplt,
  output logic             mstr1_valid,
  input  logic             mstr1_ready,
  output logic [1:0]       mstr1_mode,
  output logic [7:0]       mstr1_proc_val,
  output logic [DW-1:0]    mstr1_data,
  output logic             mstr1_cmplt,
  output logic [CNT_W-1:0] drop_cnt
);

  // Beat counter width; a one-beat frame still needs a 1-bit counter.
  localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RDWAIT = 2'd1,
    ST_SEND   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_src;
  logic [1:0]       r_valid;
  logic [1:0]       r_cmplt;
  logic [1:0]       r_mode [2];
  logic [7:0]       r_pv   [2];
  logic [DW-1:0]    r_data [2];
  logic [BW-1:0]    r_beat [2];
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_rd_req;
  logic             w_load;
  logic             w_drop;
  logic             w_hs;
  logic [1:0]       w_ready;
  logic             w_src;
  logic [1:0]       w_mode;

  assign w_ready = {mstr1_ready, mstr0_ready};
  assign w_src   = fifo_rd_data[DW+10];
  assign w_mode  = fifo_rd_data[DW+9:DW+8];

  // Next-state decode: one pop from IDLE, inspect the popped word in RDWAIT,
  // hold in SEND until the selected master takes the beat.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_req    = 1'b0;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          w_rd_req    = 1'b1;
          w_state_nxt = ST_RDWAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RDWAIT: begin
        if (w_mode == 2'b00) begin
          w_drop      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_valid[r_src] && w_ready[r_src]) begin
          w_hs        = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The pop strobe is decoded from the state register and qualified by reset
  // so that a non-empty FIFO is never read while reset is held.
  assign fifo_rd_en = w_rd_req && !rst;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Master-side valid and field registers; the unselected port keeps its fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src   <= 1'b0;
      r_valid <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_mode[i] <= 2'b00;
        r_pv[i]   <= 8'h00;
        r_data[i] <= {DW{1'b0}};
      end
    end else if (w_load) begin
      r_src          <= w_src;
      r_valid[w_src] <= 1'b1;
      r_mode[w_src]  <= w_mode;
      r_pv[w_src]    <= fifo_rd_data[DW+7:DW];
      r_data[w_src]  <= fifo_rd_data[DW-1:0];
    end else if (w_hs) begin
      r_valid[r_src] <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Per-source beat counters and the registered one-cycle frame-end pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmplt <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_beat[i] <= {BW{1'b0}};
      end
    end else begin
      r_cmplt <= 2'b00;
      if (w_hs) begin
        if (r_beat[r_src] == BW'(FRAME_BEATS - 1)) begin
          r_beat[r_src]  <= {BW{1'b0}};
          r_cmplt[r_src] <= 1'b1;
        end else begin
          r_beat[r_src] <= r_beat[r_src] + BW'(1);
        end
      end
    end
  end

  // Saturating count of mode-00 entries thrown away.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= {CNT_W{1'b0}};
    end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  assign mstr0_valid    = r_valid[0];
  assign mstr0_mode     = r_mode[0];
  assign mstr0_proc_val = r_pv[0];
  assign mstr0_data     = r_data[0];
  assign mstr0_cmplt    = r_cmplt[0];
  assign mstr1_valid    = r_valid[1];
  assign mstr1_mode     = r_mode[1];
  assign mstr1_proc_val = r_pv[1];
  assign mstr1_data     = r_data[1];
  assign mstr1_cmplt    = r_cmplt[1];
  assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_arb_result_dispatch.sv
// Testbench for arb_result_dispatch: a queue-backed FIFO feeds random tagged
// entries; a transaction-level model predicts each port's visible state.
module tb_arb_result_dispatch;

  localparam int DW = 32;
  localparam int FB = 4;
  localparam int CW = 3;
  localparam int EW = DW + 11;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [EW-1:0] fifo_rd_data = '0;
  logic          mstr0_valid, mstr1_valid;
  logic          mstr0_ready = 1'b0, mstr1_ready = 1'b0;
  logic [1:0]    mstr0_mode, mstr1_mode;
  logic [7:0]    mstr0_proc_val, mstr1_proc_val;
  logic [DW-1:0] mstr0_data, mstr1_data;
  logic          mstr0_cmplt, mstr1_cmplt;
  logic [CW-1:0] drop_cnt;

  arb_result_dispatch #(.DW(DW), .FRAME_BEATS(FB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .mstr0_valid(mstr0_valid), .mstr0_ready(mstr0_ready), .mstr0_mode(mstr0_mode),
    .mstr0_proc_val(mstr0_proc_val), .mstr0_data(mstr0_data), .mstr0_cmplt(mstr0_cmplt),
    .mstr1_valid(mstr1_valid), .mstr1_ready(mstr1_ready), .mstr1_mode(mstr1_mode),
    .mstr1_proc_val(mstr1_proc_val), .mstr1_data(mstr1_data), .mstr1_cmplt(mstr1_cmplt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // FIFO contents and reference model state
  logic [EW-1:0] q[$];
  bit            busy;          // an entry has been popped and is not yet resolved
  bit            in_flight;     // popped word is on fifo_rd_data awaiting inspection
  logic [EW-1:0] cur;           // the popped entry
  bit            exp_valid [2];
  logic [DW+9:0] exp_fields [2];
  int            delivered [2]; // beats delivered per source
  bit            exp_cmplt [2];
  int            drops;
  int            cmplt_seen [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] rand_entry(input bit allow_drop);
    logic [1:0] m;
    m = 2'($urandom_range(0, 3));
    if (!allow_drop && m == 2'b00) m = 2'b01;
    return {1'($urandom_range(0, 1)), m, 8'($urandom), 32'($urandom)};
  endfunction

  task automatic model_reset();
    busy = 1'b0;
    in_flight = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_valid[i]  = 1'b0;
      exp_fields[i] = '0;
      delivered[i]  = 0;
      exp_cmplt[i]  = 1'b0;
    end
    drops = 0;
  endtask

  // One clock: drive inputs, check visible state, then advance the model
  // across the edge. Called at #1 after a rising edge.
  task automatic cycle(input bit r, input bit rdy0, input bit rdy1, input bit push);
    bit exp_rd, did_pop;
    bit hs [2];
    bit rdy [2];
    rst = r;
    mstr0_ready = rdy0;
    mstr1_ready = rdy1;
    rdy[0] = rdy0;
    rdy[1] = rdy1;
    if (push) q.push_back(rand_entry(1'b1));
    fifo_empty = (q.size() == 0);
    #1;
    exp_rd = !r && !fifo_empty && !busy;
    chk("rd_en", fifo_rd_en, exp_rd);
    chk("valid0", mstr0_valid, exp_valid[0]);
    chk("valid1", mstr1_valid, exp_valid[1]);
    chk("cmplt0", mstr0_cmplt, exp_cmplt[0]);
    chk("cmplt1", mstr1_cmplt, exp_cmplt[1]);
    chk("drop_cnt", drop_cnt, (drops > DROP_MAX) ? DROP_MAX : drops);
    chk("fields0", {mstr0_mode, mstr0_proc_val, mstr0_data}, exp_fields[0]);
    chk("fields1", {mstr1_mode, mstr1_proc_val, mstr1_data}, exp_fields[1]);
    if (mstr0_cmplt) cmplt_seen[0]++;
    if (mstr1_cmplt) cmplt_seen[1]++;
    did_pop = fifo_rd_en;
    for (int s = 0; s < 2; s++) hs[s] = exp_valid[s] && rdy[s];
    @(posedge clk);
    #1;
    exp_cmplt[0] = 1'b0;
    exp_cmplt[1] = 1'b0;
    fifo_rd_data = {11'($urandom), 32'($urandom)};
    if (r) begin
      model_reset();
    end else begin
      if (in_flight) begin
        in_flight = 1'b0;
        if (cur[DW+9:DW+8] == 2'b00) begin
          drops++;
          busy = 1'b0;
        end else begin
          exp_valid[cur[EW-1]]  = 1'b1;
          exp_fields[cur[EW-1]] = cur[DW+9:0];
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (hs[s]) begin
          exp_valid[s] = 1'b0;
          busy = 1'b0;
          delivered[s]++;
          if (delivered[s] % FB == 0) exp_cmplt[s] = 1'b1;
        end
      end
      if (did_pop && q.size() > 0) begin
        cur = q.pop_front();
        fifo_rd_data = cur;
        in_flight = 1'b1;
        busy = 1'b1;
      end
    end
  endtask

  initial begin
    logic [EW-1:0] e;
    bit got_send;
    model_reset();
    cmplt_seen[0] = 0;
    cmplt_seen[1] = 0;
    @(posedge clk);
    #1;
    // Reset held for two cycles with a non-empty FIFO
    q.push_back({1'b1, 2'b01, 8'h5A, 32'hDEADBEEF});
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    // Single entry to master 1
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    // Backpressure on master 0 for more than ten cycles, with more entries queued
    e = rand_entry(1'b0);
    e[EW-1] = 1'b0;
    q.push_back(e);
    q.push_back(rand_entry(1'b1));
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    // Random traffic: mixed sources, drops, sporadic stalls
    for (int i = 0; i < 600; i++)
      cycle(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0));
    // Reset while an entry is being presented
    q.push_back(rand_entry(1'b0));
    got_send = 1'b0;
    for (int i = 0; i < 60 && !got_send; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      got_send = mstr0_valid || mstr1_valid;
    end
    chk("send_reached", got_send, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++)
      cycle(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0));
    for (int i = 0; i < 150; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("fifo_drained", q.size(), 0);
    chk("cmplt0_seen", (cmplt_seen[0] > 0), 1'b1);
    chk("cmplt1_seen", (cmplt_seen[1] > 0), 1'b1);
    chk("drop_saturated", drop_cnt, DROP_MAX);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
